// File: rtl/sfx_channel_arbiter.sv
// sfx_channel_arbiter
// Owns the left/right tone path into the divider stage. BGM passes through
// while idle; a granted sound effect preempts both channels for a number of
// beats, followed by an optional silent gap. bgm_hold pauses the music
// player's beat counter so the song resumes where it stopped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   beat_tick         one-cycle pulse per music beat
//   bgm_en            BGM enable (idle output is silence when low)
//   bgm_toneL/R       BGM tones in Hz, 0 = rest
//   sfx_req           level requests, index 0 highest priority
//   sfx_tone/sfx_dur  packed per-requester tone (Hz) and duration (beats)
//   sfx_ack           one-cycle grant pulse
//   freqL/freqR       frequencies to the divider stage (never 0)
//   volume            volume code to the note generator
//   bgm_hold          pause request to the player controller
//   busy              high in PLAY or GAP
//   active_id         index of the SFX currently playing
module sfx_channel_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DUR_W      = 4,
  parameter int ID_W       = 2,
  parameter int SILENCE_HZ = 20000,
  parameter int BGM_VOL    = 3,
  parameter int SFX_VOL    = 5,
  parameter int GAP_BEATS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat_tick,
  input  logic                   bgm_en,
  input  logic [31:0]            bgm_toneL,
  input  logic [31:0]            bgm_toneR,
  input  logic [N_REQ-1:0]       sfx_req,
  input  logic [N_REQ*32-1:0]    sfx_tone,
  input  logic [N_REQ*DUR_W-1:0] sfx_dur,
  output logic [N_REQ-1:0]       sfx_ack,
  output logic [31:0]            freqL,
  output logic [31:0]            freqR,
  output logic [2:0]             volume,
  output logic                   bgm_hold,
  output logic                   busy,
  output logic [ID_W-1:0]        active_id
);

  localparam logic [31:0] SIL = 32'(SILENCE_HZ);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state, nxt_state;
  logic [DUR_W-1:0] cnt, lat_dur, g_dur;
  logic [31:0]      lat_tone, g_tone;
  logic [ID_W-1:0]  gnt_idx;
  logic             any_req, do_grant, play_done, gap_done;

  // Downstream divides by the frequency, so a rest (0) becomes SILENCE_HZ.
  function automatic logic [31:0] nz(input logic [31:0] t);
    return (t == 32'd0) ? SIL : t;
  endfunction

  always_comb begin
    any_req = |sfx_req;
    gnt_idx = '0;
    g_tone  = '0;
    g_dur   = '0;
    // Descending scan so the lowest set index wins.
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (sfx_req[i]) begin
        gnt_idx = ID_W'(i);
        g_tone  = sfx_tone[i*32 +: 32];
        g_dur   = sfx_dur[i*DUR_W +: DUR_W];
      end
    end

    // In PLAY only a strictly higher-priority requester may preempt; the
    // lowest set index is below active_id iff any such requester exists.
    do_grant = any_req && ((state != PLAY) || (gnt_idx < active_id));

    play_done = beat_tick && ((cnt + 1'b1) == lat_dur);
    gap_done  = beat_tick && ((cnt + 1'b1) == DUR_W'(GAP_BEATS));

    nxt_state = state;
    if (do_grant) nxt_state = PLAY;
    else begin
      case (state)
        PLAY:    if (play_done) nxt_state = (GAP_BEATS == 0) ? IDLE : GAP;
        GAP:     if (gap_done) nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_tone  <= '0;
      lat_dur   <= '0;
      sfx_ack   <= '0;
      active_id <= '0;
      freqL     <= SIL;
      freqR     <= SIL;
      volume    <= 3'(BGM_VOL);
      bgm_hold  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state   <= nxt_state;
      sfx_ack <= '0;

      if (do_grant) begin
        lat_tone         <= g_tone;
        lat_dur          <= (g_dur == '0) ? DUR_W'(1) : g_dur;
        sfx_ack[gnt_idx] <= 1'b1;
        active_id        <= gnt_idx;
      end

      // Counter restarts on every grant and state change; ticks in the
      // deciding cycle are therefore never counted.
      if (do_grant || (nxt_state != state)) cnt <= '0;
      else if (beat_tick && (state != IDLE)) cnt <= cnt + 1'b1;

      // Outputs follow the next state so hold and tone switch together.
      case (nxt_state)
        PLAY: begin
          freqL    <= nz(do_grant ? g_tone : lat_tone);
          freqR    <= nz(do_grant ? g_tone : lat_tone);
          volume   <= 3'(SFX_VOL);
          bgm_hold <= 1'b1;
          busy     <= 1'b1;
        end
        GAP: begin
          freqL    <= SIL;
          freqR    <= SIL;
          volume   <= 3'(BGM_VOL);
          bgm_hold <= 1'b1;
          busy     <= 1'b1;
        end
        default: begin
          freqL    <= bgm_en ? nz(bgm_toneL) : SIL;
          freqR    <= bgm_en ? nz(bgm_toneR) : SIL;
          volume   <= 3'(BGM_VOL);
          bgm_hold <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_channel_arbiter.sv
// Directed bench for sfx_channel_arbiter with hand-computed expectations.
module tb_sfx_channel_arbiter;

  localparam int N_REQ = 4, DUR_W = 4, ID_W = 2;

  logic                   clk = 1'b0;
  logic                   rst, beat_tick, bgm_en;
  logic [31:0]            bgm_toneL, bgm_toneR;
  logic [N_REQ-1:0]       sfx_req;
  logic [N_REQ*32-1:0]    sfx_tone;
  logic [N_REQ*DUR_W-1:0] sfx_dur;
  logic [N_REQ-1:0]       sfx_ack;
  logic [31:0]            freqL, freqR;
  logic [2:0]             volume;
  logic                   bgm_hold, busy;
  logic [ID_W-1:0]        active_id;

  int errs = 0, checks = 0;

  sfx_channel_arbiter dut (
    .clk(clk), .rst(rst), .beat_tick(beat_tick), .bgm_en(bgm_en),
    .bgm_toneL(bgm_toneL), .bgm_toneR(bgm_toneR), .sfx_req(sfx_req),
    .sfx_tone(sfx_tone), .sfx_dur(sfx_dur), .sfx_ack(sfx_ack),
    .freqL(freqL), .freqR(freqR), .volume(volume), .bgm_hold(bgm_hold),
    .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the next negedge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    step(1);
    beat_tick = 1'b0;
  endtask

  task automatic set_sfx(input int i, input logic [31:0] t, input logic [3:0] d);
    sfx_tone[i*32 +: 32]      = t;
    sfx_dur[i*DUR_W +: DUR_W] = d;
  endtask

  initial begin
    rst = 1'b1; beat_tick = 1'b0; bgm_en = 1'b0;
    bgm_toneL = 32'd0; bgm_toneR = 32'd0;
    sfx_req = 4'b1111; sfx_tone = '0; sfx_dur = '0;
    set_sfx(0, 500, 2); set_sfx(1, 1047, 3); set_sfx(2, 880, 3); set_sfx(3, 1500, 1);
    @(negedge clk);

    // Reset held with all requests pending
    step(2);
    chk("rst_freqL", freqL, 20000);
    chk("rst_freqR", freqR, 20000);
    chk("rst_ack", 32'(sfx_ack), 0);
    chk("rst_hold", 32'(bgm_hold), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vol", 32'(volume), 3);
    rst = 1'b0;
    step(1);
    chk("post_rst_ack", 32'(sfx_ack), 4'b0001);
    chk("post_rst_freq", freqL, 500);
    chk("post_rst_hold", 32'(bgm_hold), 1);
    sfx_req = 4'b0000;
    step(1);

    // Reset mid-PLAY aborts immediately
    rst = 1'b1;
    step(1);
    chk("midrst_freq", freqL, 20000);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_hold", 32'(bgm_hold), 0);
    rst = 1'b0;
    step(1);

    // Passthrough with zero mapping on the right
    bgm_en = 1'b1; bgm_toneL = 262; bgm_toneR = 0;
    step(1);
    chk("pass_L", freqL, 262);
    chk("pass_R", freqR, 20000);
    chk("pass_vol", 32'(volume), 3);

    // Basic SFX on requester 2, 3 beats then one gap beat
    sfx_req = 4'b0100;
    step(1);
    chk("b_ack", 32'(sfx_ack), 4'b0100);
    chk("b_L", freqL, 880);
    chk("b_R", freqR, 880);
    chk("b_id", 32'(active_id), 2);
    chk("b_vol", 32'(volume), 5);
    chk("b_hold", 32'(bgm_hold), 1);
    sfx_req = 4'b0000;
    step(1);
    chk("b_ack_once", 32'(sfx_ack), 0);
    step(6); tick(); chk("b_t1", freqL, 880);
    step(7); tick(); chk("b_t2", freqR, 880);
    step(7); tick(); chk("b_gap_L", freqL, 20000);
    chk("b_gap_vol", 32'(volume), 3);
    chk("b_gap_hold", 32'(bgm_hold), 1);
    step(3); chk("b_gap_stay", freqL, 20000);
    step(4); tick();
    chk("b_ret_L", freqL, 262);
    chk("b_ret_hold", 32'(bgm_hold), 0);
    chk("b_ret_busy", 32'(busy), 0);

    // Preemption with requester 3 pending throughout
    step(2);
    sfx_req = 4'b1100;
    step(1);
    chk("p_ack2", 32'(sfx_ack), 4'b0100);
    sfx_req = 4'b1000;
    step(1);
    chk("p_pend", 32'(sfx_ack), 0);
    tick(); tick();                 // SFX 2 counter at 2 of 3
    step(2);
    sfx_req = 4'b1010;
    step(1);
    chk("p_ack1", 32'(sfx_ack), 4'b0010);
    chk("p_L", freqL, 1047);
    chk("p_id", 32'(active_id), 1);
    sfx_req = 4'b1000;
    step(2);
    tick(); chk("p_restart", freqL, 1047);
    chk("p_noack3", 32'(sfx_ack), 0);
    tick(); chk("p_t2", freqL, 1047);
    tick(); chk("p_gap", freqL, 20000);
    chk("p_gap_ack", 32'(sfx_ack), 0);
    step(1);
    chk("p_ack3", 32'(sfx_ack), 4'b1000);
    chk("p_L3", freqL, 1500);
    chk("p_id3", 32'(active_id), 3);
    sfx_req = 4'b0000;
    step(2);
    tick(); chk("p3_gap", freqL, 20000);
    tick(); chk("p3_idle", freqL, 262);

    // Zero duration lasts one beat; zero tone maps to silence
    set_sfx(0, 0, 0);
    step(2);
    sfx_req = 4'b0001;
    step(1);
    chk("z_ack", 32'(sfx_ack), 4'b0001);
    chk("z_L", freqL, 20000);
    chk("z_vol", 32'(volume), 5);
    sfx_req = 4'b0000;
    step(2);
    tick(); chk("z_gap_vol", 32'(volume), 3);
    chk("z_gap_busy", 32'(busy), 1);
    tick(); chk("z_idle", freqL, 262);

    // Simultaneous 0 and 3: only 0 granted, 3 served after
    set_sfx(0, 700, 1);
    step(2);
    sfx_req = 4'b1001;
    step(1);
    chk("s_ack0", 32'(sfx_ack), 4'b0001);
    chk("s_L", freqL, 700);
    sfx_req = 4'b1000;
    step(1);
    chk("s_noack", 32'(sfx_ack), 0);
    tick(); chk("s_gap", freqL, 20000);
    step(1);
    chk("s_ack3", 32'(sfx_ack), 4'b1000);
    sfx_req = 4'b0000;
    step(1);
    tick(); tick();
    chk("s_idle", freqL, 262);

    // BGM disabled: idle is silence
    bgm_en = 1'b0;
    step(1);
    chk("dis_L", freqL, 20000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
